// File: rtl/red_pitaya_pid_tdm.sv
// red_pitaya_pid_tdm
//   CNO x CNI MIMO PID controller. One shared multiply datapath is stepped
//   over every path p = o*CNI + i. Path results are summed per output, and
//   each sum is clamped to a per-output [lmin, lmax] window.
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   sti_dat/vld/rdy      input frame stream, channel i at [i*DWI +: DWI]
//   sto_dat/vld/rdy      output frame stream, channel o at [o*DWO +: DWO]
//   cfg_sp/kp/ki/kd      per-path set point and gains
//   cfg_irst             per-path integrator clear (level)
//   cfg_hold             freeze all integrators
//   cfg_lmin/lmax        per-output clamp window
//   sts_sat              per-output clamped flag, qualified by sto_vld
module red_pitaya_pid_tdm #(
  parameter int DWI = 14,
  parameter int DWO = 14,
  parameter int CNI = 2,
  parameter int CNO = 2,
  parameter int KW  = 14,
  parameter int IW  = 32,
  parameter int PSR = 12,
  parameter int ISR = 18,
  parameter int DSR = 10
)(
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [CNI*DWI-1:0]     sti_dat,
  input  logic                   sti_vld,
  output logic                   sti_rdy,
  output logic [CNO*DWO-1:0]     sto_dat,
  output logic                   sto_vld,
  input  logic                   sto_rdy,
  input  logic [CNO*CNI*DWI-1:0] cfg_sp,
  input  logic [CNO*CNI*KW-1:0]  cfg_kp,
  input  logic [CNO*CNI*KW-1:0]  cfg_ki,
  input  logic [CNO*CNI*KW-1:0]  cfg_kd,
  input  logic [CNO*CNI-1:0]     cfg_irst,
  input  logic                   cfg_hold,
  input  logic [CNO*DWO-1:0]     cfg_lmin,
  input  logic [CNO*DWO-1:0]     cfg_lmax,
  output logic [CNO-1:0]         sts_sat
);

  localparam int N   = CNO*CNI;
  localparam int IXW = (N   > 1) ? $clog2(N)   : 1;
  localparam int OXW = (CNO > 1) ? $clog2(CNO) : 1;
  localparam int CXW = (CNI > 1) ? $clog2(CNI) : 1;
  localparam int EW  = DWI + 1;
  localparam int PW  = KW + EW;
  localparam int DPW = KW + EW + 1;
  localparam int MW  = (PW > IW) ? PW : IW;
  localparam int SW  = ((DPW > MW) ? DPW : MW) + 2;
  localparam int AW  = DWO + $clog2(CNI) + 1;

  localparam logic signed [SW-1:0] PID_MAX = {{(SW-DWO+1){1'b0}}, {(DWO-1){1'b1}}};
  localparam logic signed [SW-1:0] PID_MIN = {{(SW-DWO+1){1'b1}}, {(DWO-1){1'b0}}};
  localparam logic signed [IW:0]   INT_MAX = {2'b00, {(IW-1){1'b1}}};
  localparam logic signed [IW:0]   INT_MIN = {2'b11, {(IW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state_q, state_d;

  logic [IXW-1:0]          idx;
  logic [OXW-1:0]          oc, o_r;
  logic [CXW-1:0]          ic;
  logic signed [DWI-1:0]   x_r    [CNI];
  logic signed [IW-1:0]    integ  [N];
  logic signed [EW-1:0]    e_prev [N];
  logic signed [AW-1:0]    acc    [CNO];
  logic                    pv;
  logic signed [DWO-1:0]   pid_r;

  // path datapath (stage 1)
  logic signed [DWI-1:0] sp_sel;
  logic signed [KW-1:0]  kp_sel, ki_sel, kd_sel;
  logic signed [EW-1:0]  e;
  logic signed [EW:0]    de;
  logic signed [PW-1:0]  p_prod, i_prod;
  logic signed [DPW-1:0] d_prod;
  logic signed [IW:0]    i_sum;
  logic signed [IW-1:0]  i_sat, i_nxt;
  logic signed [SW-1:0]  pid_sum;
  logic signed [DWO-1:0] pid;

  // output clamp
  logic [CNO*DWO-1:0]    dat_nxt;
  logic [CNO-1:0]        sat_nxt;
  logic signed [AW-1:0]  fin, lo, hi;

  assign sti_rdy = rstn && (state_q == IDLE);
  assign sto_vld = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sti_vld) state_d = RUN;
      RUN:     if (idx == IXW'(N-1)) state_d = FLUSH;
      FLUSH:   state_d = DONE;
      DONE:    if (sto_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sp_sel = cfg_sp[idx*DWI +: DWI];
    kp_sel = cfg_kp[idx*KW +: KW];
    ki_sel = cfg_ki[idx*KW +: KW];
    kd_sel = cfg_kd[idx*KW +: KW];
    e      = EW'(sp_sel) - EW'(x_r[ic]);
    de     = (EW+1)'(e) - (EW+1)'(e_prev[idx]);
    p_prod = PW'(kp_sel) * PW'(e);
    i_prod = PW'(ki_sel) * PW'(e);
    d_prod = DPW'(kd_sel) * DPW'(de);
    i_sum  = (IW+1)'(integ[idx]) + (IW+1)'(i_prod);
    if (i_sum > INT_MAX)      i_sat = IW'(INT_MAX);
    else if (i_sum < INT_MIN) i_sat = IW'(INT_MIN);
    else                      i_sat = IW'(i_sum);
    if (cfg_irst[idx])  i_nxt = '0;
    else if (cfg_hold)  i_nxt = integ[idx];
    else                i_nxt = i_sat;
    // terms are summed at full width so the output saturation is exact
    pid_sum = SW'(p_prod >>> PSR) + SW'(i_nxt >>> ISR) + SW'(d_prod >>> DSR);
    if (pid_sum > PID_MAX)      pid = DWO'(PID_MAX);
    else if (pid_sum < PID_MIN) pid = DWO'(PID_MIN);
    else                        pid = DWO'(pid_sum);
  end

  // final sum folds in the last path still sitting in the pipeline register
  always_comb begin
    dat_nxt = '0;
    sat_nxt = '0;
    fin     = '0;
    lo      = '0;
    hi      = '0;
    for (int unsigned o = 0; o < CNO; o++) begin
      fin = acc[o];
      if (pv && (o_r == OXW'(o))) fin = acc[o] + AW'(pid_r);
      lo = AW'($signed(cfg_lmin[o*DWO +: DWO]));
      hi = AW'($signed(cfg_lmax[o*DWO +: DWO]));
      if (lo > hi) begin
        dat_nxt[o*DWO +: DWO] = DWO'(lo);
        sat_nxt[o]            = 1'b1;
      end else if (fin > hi) begin
        dat_nxt[o*DWO +: DWO] = DWO'(hi);
        sat_nxt[o]            = 1'b1;
      end else if (fin < lo) begin
        dat_nxt[o*DWO +: DWO] = DWO'(lo);
        sat_nxt[o]            = 1'b1;
      end else begin
        dat_nxt[o*DWO +: DWO] = DWO'(fin);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      idx     <= '0;
      oc      <= '0;
      ic      <= '0;
      o_r     <= '0;
      pv      <= 1'b0;
      pid_r   <= '0;
      sto_dat <= '0;
      sts_sat <= '0;
      for (int unsigned i = 0; i < CNI; i++) x_r[i] <= '0;
      for (int unsigned q = 0; q < N; q++) begin
        integ[q]  <= '0;
        e_prev[q] <= '0;
      end
      for (int unsigned o = 0; o < CNO; o++) acc[o] <= '0;
    end else begin
      pv    <= (state_q == RUN);
      pid_r <= pid;
      o_r   <= oc;
      // a path's own slot takes precedence; otherwise irst clears it any cycle
      for (int unsigned q = 0; q < N; q++) begin
        if ((state_q == RUN) && (idx == IXW'(q))) begin
          integ[q]  <= i_nxt;
          e_prev[q] <= e;
        end else if (cfg_irst[q]) begin
          integ[q] <= '0;
        end
      end
      case (state_q)
        IDLE: begin
          if (sti_vld) begin
            for (int unsigned i = 0; i < CNI; i++) x_r[i] <= sti_dat[i*DWI +: DWI];
            for (int unsigned o = 0; o < CNO; o++) acc[o] <= '0;
            idx <= '0;
            oc  <= '0;
            ic  <= '0;
          end
        end
        RUN: begin
          if (pv) acc[o_r] <= acc[o_r] + AW'(pid_r);
          if (idx != IXW'(N-1)) begin
            idx <= idx + 1'b1;
            if (ic == CXW'(CNI-1)) begin
              ic <= '0;
              oc <= oc + 1'b1;
            end else begin
              ic <= ic + 1'b1;
            end
          end
        end
        FLUSH: begin
          sto_dat <= dat_nxt;
          sts_sat <= sat_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_red_pitaya_pid_tdm.sv
// tb_red_pitaya_pid_tdm
//   Scoreboard bench for red_pitaya_pid_tdm in its 2x2 configuration.
//   Stimulus pushes expected frames; a negedge monitor pops and compares.
module tb_red_pitaya_pid_tdm;

  logic        clk = 1'b0;
  logic        rstn;
  logic [27:0] sti_dat;
  logic        sti_vld;
  logic        sti_rdy;
  logic [27:0] sto_dat;
  logic        sto_vld;
  logic        sto_rdy;
  logic [55:0] cfg_sp, cfg_kp, cfg_ki, cfg_kd;
  logic [3:0]  cfg_irst;
  logic        cfg_hold;
  logic [27:0] cfg_lmin, cfg_lmax;
  logic [1:0]  sts_sat;

  always #5 clk = ~clk;

  red_pitaya_pid_tdm #(
    .DWI(14), .DWO(14), .CNI(2), .CNO(2), .KW(14),
    .IW(32), .PSR(12), .ISR(18), .DSR(10)
  ) dut (
    .clk(clk), .rstn(rstn),
    .sti_dat(sti_dat), .sti_vld(sti_vld), .sti_rdy(sti_rdy),
    .sto_dat(sto_dat), .sto_vld(sto_vld), .sto_rdy(sto_rdy),
    .cfg_sp(cfg_sp), .cfg_kp(cfg_kp), .cfg_ki(cfg_ki), .cfg_kd(cfg_kd),
    .cfg_irst(cfg_irst), .cfg_hold(cfg_hold),
    .cfg_lmin(cfg_lmin), .cfg_lmax(cfg_lmax), .sts_sat(sts_sat)
  );

  typedef struct {
    logic [27:0] dat;
    logic [1:0]  sat;
    int          acc_cyc;
    string       nm;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_acc = 0;
  int   rel_cyc  = 0;
  logic vld_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s actual=event expected=none", nm);
  endtask

  function automatic logic [27:0] pk(input int a, input int b);
    pk = {14'(b), 14'(a)};
  endfunction

  // monitor: latency on the rising edge of sto_vld, data on handshake
  always @(negedge clk) begin : mon
    exp_t m;
    if (rstn) begin
      if (sto_vld && !vld_prev) begin
        if (sbq.size() == 0) fail("unexpected_vld");
        else chk({sbq[0].nm, "_lat"}, 64'(cyc - sbq[0].acc_cyc), 64'd6);
      end
      if (sto_vld && sto_rdy) begin
        if (sbq.size() == 0) begin
          fail("unexpected_out");
        end else begin
          m = sbq.pop_front();
          chk({m.nm, "_dat"}, 64'(sto_dat), 64'(m.dat));
          chk({m.nm, "_sat"}, 64'(sts_sat), 64'(m.sat));
        end
      end
    end
    vld_prev = sto_vld;
  end

  task automatic clear_cfg();
    cfg_sp   = '0;
    cfg_kp   = '0;
    cfg_ki   = '0;
    cfg_kd   = '0;
    cfg_irst = '0;
    cfg_hold = 1'b0;
    cfg_lmin = {14'h2000, 14'h2000};
    cfg_lmax = {14'h1FFF, 14'h1FFF};
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rstn = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_sti_rdy", 64'(sti_rdy), 64'd0);
    chk("rst_sto_vld", 64'(sto_vld), 64'd0);
    chk("rst_sto_dat", 64'(sto_dat), 64'd0);
    chk("rst_sts_sat", 64'(sts_sat), 64'd0);
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    chk("rel_sti_rdy", 64'(sti_rdy), 64'd1);
  endtask

  task automatic send(input int x0, input int x1, input bit expect_out,
                      input int o0, input int o1, input logic [1:0] es, input string nm);
    bit got;
    exp_t t;
    got = 1'b0;
    @(posedge clk); #1;
    sti_dat = pk(x0, x1);
    sti_vld = 1'b1;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (sti_rdy) got = 1'b1;
    end
    if (!got) begin
      fail({nm, "_accept_timeout"});
      sti_vld = 1'b0;
      return;
    end
    last_acc = cyc;
    if (expect_out) begin
      t.dat = pk(o0, o1); t.sat = es; t.acc_cyc = cyc; t.nm = nm;
      sbq.push_back(t);
    end
    @(posedge clk); #1 sti_vld = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && sbq.size() != 0; n++) @(negedge clk);
    if (sbq.size() != 0) begin
      fail("drain_timeout");
      sbq.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; sti_vld = 1'b0; sti_dat = '0; sto_rdy = 1'b1;
    clear_cfg();
    do_reset();

    // proportional path only
    cfg_kp[0 +: 14] = 14'd4096;
    cfg_sp[0 +: 14] = 14'd1000;
    send(0, 0, 1, 1000, 0, 2'b00, "p_basic");
    drain();

    // two paths into output 0, clamp window boundaries
    clear_cfg();
    cfg_kp[0 +: 14] = 14'd4096;  cfg_kp[14 +: 14] = 14'd4096;
    cfg_sp[0 +: 14] = 14'd4000;  cfg_sp[14 +: 14] = 14'd4000;
    send(0, 0, 1, 8000, 0, 2'b00, "sum_inside");
    drain();
    cfg_sp[0 +: 14] = 14'd8000;  cfg_sp[14 +: 14] = 14'd8000;
    send(0, 0, 1, 8191, 0, 2'b01, "clamp_hi");
    drain();
    cfg_lmax[0 +: 14] = 14'd500;
    send(0, 0, 1, 500, 0, 2'b01, "clamp_500");
    drain();
    cfg_lmin[0 +: 14] = 14'd600;
    cfg_lmin[14 +: 14] = 14'd10; cfg_lmax[14 +: 14] = 14'd5;
    send(0, 0, 1, 600, 10, 2'b11, "lmin_gt_lmax");
    drain();
    cfg_lmin = {14'h2000, 14'h2000};
    cfg_lmax = {14'h1FFF, 14'h1FFF};
    cfg_sp[0 +: 14] = 14'(-8000); cfg_sp[14 +: 14] = 14'(-8000);
    send(0, 0, 1, -8192, 0, 2'b01, "clamp_lo");
    drain();

    // integrator, hold, irst
    do_reset();
    clear_cfg();
    cfg_ki[28 +: 14] = 14'd4096;
    cfg_sp[28 +: 14] = 14'd64;
    for (int k = 1; k <= 5; k++) send(0, 0, 1, 0, k, 2'b00, "int_acc");
    drain();
    cfg_hold = 1'b1;
    send(0, 0, 1, 0, 5, 2'b00, "int_hold");
    send(0, 0, 1, 0, 5, 2'b00, "int_hold");
    drain();
    cfg_irst[2] = 1'b1;
    send(0, 0, 1, 0, 0, 2'b00, "int_irst");
    drain();
    cfg_irst[2] = 1'b0; cfg_hold = 1'b0;
    send(0, 0, 1, 0, 1, 2'b00, "int_restart");
    drain();

    // derivative
    do_reset();
    clear_cfg();
    cfg_kd[0 +: 14] = 14'd1024;
    send(0, 0, 1, 0, 0, 2'b00, "d_zero");
    send(-100, 0, 1, 100, 0, 2'b00, "d_step");
    send(-100, 0, 1, 0, 0, 2'b00, "d_flat");
    drain();

    // backpressure while a new frame is waiting
    clear_cfg();
    cfg_kp[0 +: 14] = 14'd4096;
    cfg_sp[0 +: 14] = 14'd1000;
    sto_rdy = 1'b0;
    fork
      begin
        send(0, 0, 1, 1000, 0, 2'b00, "stall_a");
        send(200, 0, 1, 800, 0, 2'b00, "stall_b");
      end
      begin
        for (int n = 0; n < 50 && !sto_vld; n++) @(negedge clk);
        chk("stall_vld_seen", 64'(sto_vld), 64'd1);
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          chk("stall_vld", 64'(sto_vld), 64'd1);
          chk("stall_dat", 64'(sto_dat), 64'(pk(1000, 0)));
          chk("stall_rdy", 64'(sti_rdy), 64'd0);
        end
        @(posedge clk); #1 sto_rdy = 1'b1;
        @(negedge clk);
        rel_cyc = cyc;
      end
    join
    chk("accept_after_rdy", 64'(last_acc - rel_cyc), 64'd1);
    drain();

    // reset in the middle of a frame
    do_reset();
    clear_cfg();
    cfg_ki[28 +: 14] = 14'd4096;
    cfg_sp[28 +: 14] = 14'd64;
    send(0, 0, 1, 0, 1, 2'b00, "pre_abort1");
    send(0, 0, 1, 0, 2, 2'b00, "pre_abort2");
    drain();
    send(0, 0, 0, 0, 0, 2'b00, "abort");
    @(posedge clk); #1;
    @(posedge clk); #1 rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("abort_vld", 64'(sto_vld), 64'd0);
    end
    send(0, 0, 1, 0, 1, 2'b00, "post_abort");
    drain();
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
